// File: rtl/game_judge.sv
`default_nettype none
// =====================================================================
// Module  : game_judge
// Brief   : Tic-tac-toe win/draw referee; scans the 8 lines one per
//           cycle after each board change. Optional feature macro:
//           GAME_JUDGE_AUTOCLR_EN (auto-clear game_over after hold time)
// Rev     : 1.0  initial release
// =====================================================================
module game_judge #(
    parameter int SCORE_W     = 8,
    parameter int HOLD_CYCLES = 75000000
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [8:0]         square1to9,
    input  logic [8:0]         square1to9_color,
    input  logic               clr_game,
    input  logic               clr_score,
    output logic               busy,
    output logic               result_valid,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [2:0]         win_line,
    output logic [SCORE_W-1:0] score_p0,
    output logic [SCORE_W-1:0] score_p1
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_EVAL    = 2'd2;
    localparam logic [8:0] FULL_BOARD = 9'h1FF;
    localparam logic [2:0] LAST_LINE  = 3'd7;

    logic [1:0]         state_q, state_d;
    logic [8:0]         occ_in_q, col_in_q;
    logic [8:0]         snap_occ_q, snap_col_q;
    logic [2:0]         line_q;
    logic               found_q, found_owner_q;
    logic [2:0]         found_line_q;
    logic               rv_q, go_q;
    logic [1:0]         winner_q;
    logic [2:0]         win_line_q;
    logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;

    logic               w_change, w_clr, w_auto_clr;
    logic               w_capture, w_scan, w_eval, w_set_over;
    logic [8:0]         w_mask;
    logic               w_line_won, w_line_owner;

    function automatic logic [8:0] line_mask(input logic [2:0] idx);
        logic [8:0] m;
        case (idx)
            3'd0:    m = 9'b000_000_111;
            3'd1:    m = 9'b000_111_000;
            3'd2:    m = 9'b111_000_000;
            3'd3:    m = 9'b001_001_001;
            3'd4:    m = 9'b010_010_010;
            3'd5:    m = 9'b100_100_100;
            3'd6:    m = 9'b100_010_001;
            default: m = 9'b001_010_100;
        endcase
        return m;
    endfunction

    // Colour inputs are stored pre-masked, so unoccupied squares never count as a change
    assign w_change     = {occ_in_q, col_in_q} != {snap_occ_q, snap_col_q};
    assign w_clr        = clr_game | w_auto_clr;
    assign w_mask       = line_mask(line_q);
    assign w_line_owner = (snap_col_q & w_mask) == w_mask;
    assign w_line_won   = ((snap_occ_q & w_mask) == w_mask) &&
                          (w_line_owner || ((snap_col_q & w_mask) == 9'd0));
    assign w_set_over   = w_eval && (found_q || (snap_occ_q == FULL_BOARD));

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_capture) state_d = ST_SCAN;
            ST_SCAN: if (!w_change && (line_q == LAST_LINE)) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_clr) state_d = ST_IDLE;
    end

    always_comb begin
        w_capture = 1'b0;
        w_scan    = 1'b0;
        w_eval    = 1'b0;
        case (state_q)
            ST_IDLE: w_capture = w_change && !go_q;
            ST_SCAN: begin
                w_capture = w_change;
                w_scan    = !w_change;
            end
            ST_EVAL: w_eval = !w_clr;
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge pclk) begin
        if (rst) begin
            occ_in_q      <= '0;
            col_in_q      <= '0;
            snap_occ_q    <= '0;
            snap_col_q    <= '0;
            line_q        <= '0;
            found_q       <= 1'b0;
            found_owner_q <= 1'b0;
            found_line_q  <= '0;
            rv_q          <= 1'b0;
            go_q          <= 1'b0;
            winner_q      <= '0;
            win_line_q    <= '0;
        end else begin
            occ_in_q <= square1to9;
            col_in_q <= square1to9_color & square1to9;
            rv_q     <= w_eval;
            if (w_capture) begin
                snap_occ_q <= occ_in_q;
                snap_col_q <= col_in_q;
                line_q     <= '0;
                found_q    <= 1'b0;
            end else if (w_scan) begin
                line_q <= line_q + 3'd1;
                if (w_line_won && !found_q) begin
                    found_q       <= 1'b1;
                    found_line_q  <= line_q;
                    found_owner_q <= w_line_owner;
                end
            end
            if (w_set_over) begin
                go_q <= 1'b1;
                if (found_q) begin
                    winner_q   <= found_owner_q ? 2'b10 : 2'b01;
                    win_line_q <= found_line_q;
                end else begin
                    winner_q <= 2'b11;
                end
            end
            if (w_clr) begin
                snap_occ_q <= '0;
                snap_col_q <= '0;
                go_q       <= 1'b0;
                winner_q   <= '0;
                win_line_q <= '0;
            end
        end
    end

    // Saturating scores; a same-cycle clear wins over the increment
    always_comb begin
        score0_d = score0_q;
        score1_d = score1_q;
        if (clr_score) begin
            score0_d = '0;
            score1_d = '0;
        end else if (w_eval && found_q) begin
            if (found_owner_q) begin
                if (score1_q != '1) score1_d = score1_q + SCORE_W'(1);
            end else begin
                if (score0_q != '1) score0_d = score0_q + SCORE_W'(1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            score0_q <= '0;
            score1_q <= '0;
        end else begin
            score0_q <= score0_d;
            score1_q <= score1_d;
        end
    end

`ifdef GAME_JUDGE_AUTOCLR_EN
    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              hold_run_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_run_q <= 1'b0;
        end else if (w_clr) begin
            hold_run_q <= 1'b0;
        end else if (w_set_over) begin
            hold_q     <= HOLD_LOAD;
            hold_run_q <= 1'b1;
        end else if (hold_run_q) begin
            hold_q <= hold_q - HOLD_W'(1);
        end
    end

    assign w_auto_clr = hold_run_q && (hold_q == '0);
`else
    // Hold time has no effect without auto-clear; this expression is constant 0
    assign w_auto_clr = (HOLD_CYCLES < 0);
`endif

    assign result_valid = rv_q;
    assign game_over    = go_q;
    assign winner       = winner_q;
    assign win_line     = win_line_q;
    assign score_p0     = score0_q;
    assign score_p1     = score1_q;

endmodule
`default_nettype wire

// File: tb/tb_game_judge.sv
`default_nettype none
// =====================================================================
// Module  : tb_game_judge
// Brief   : Self-checking bench for game_judge (vector table, directed
//           corner sequences, randomized games against a line model)
// Rev     : 1.0  initial release
// =====================================================================
module tb_game_judge;

    localparam int SCORE_W     = 2;
    localparam int HOLD_CYCLES = 20;
    localparam int SMAX        = 3;

    logic               pclk = 1'b0;
    logic               rst  = 1'b1;
    logic [8:0]         square1to9 = '0;
    logic [8:0]         square1to9_color = '0;
    logic               clr_game = 1'b0;
    logic               clr_score = 1'b0;
    logic               busy, result_valid, game_over;
    logic [1:0]         winner;
    logic [2:0]         win_line;
    logic [SCORE_W-1:0] score_p0, score_p1;

    game_judge #(.SCORE_W(SCORE_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .pclk(pclk), .rst(rst),
        .square1to9(square1to9), .square1to9_color(square1to9_color),
        .clr_game(clr_game), .clr_score(clr_score),
        .busy(busy), .result_valid(result_valid), .game_over(game_over),
        .winner(winner), .win_line(win_line),
        .score_p0(score_p0), .score_p1(score_p1)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [8:0] occ;
        logic [8:0] col;
        int         win;
        int         line;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int sc0 = 0, sc1 = 0;
    int e_go = 0, e_win = 0, e_line = 0;
    int LINES[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v < SMAX) ? v + 1 : v;
    endfunction

    // Reference: first line in index order with three equal occupied squares
    function automatic void judge(input logic [8:0] occ, input logic [8:0] col,
                                  output int win, output int line);
        win  = 0;
        line = 0;
        for (int l = 0; l < 8; l++) begin
            int a, b, c;
            a = LINES[l][0]; b = LINES[l][1]; c = LINES[l][2];
            if (win == 0 && occ[a] && occ[b] && occ[c] &&
                col[a] == col[b] && col[b] == col[c]) begin
                win  = col[a] ? 2 : 1;
                line = l;
            end
        end
        if (win == 0 && occ == 9'h1FF) win = 3;
    endfunction

    task automatic set_board(input logic [8:0] o, input logic [8:0] c);
        square1to9       = o;
        square1to9_color = c;
    endtask

    task automatic new_round();
        set_board(9'h000, 9'h000);
        clr_game = 1'b1;
        tick();
        clr_game = 1'b0;
        tick();
        e_go = 0; e_win = 0; e_line = 0;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (result_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic apply_result(input int win, input int line);
        if (win != 0) begin
            e_go   = 1;
            e_win  = win;
            e_line = (win == 3) ? 0 : line;
            if (win == 1) sc0 = sat(sc0);
            if (win == 2) sc1 = sat(sc1);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".game_over"}, int'(game_over), e_go);
        check({tag, ".winner"},    int'(winner),    e_win);
        check({tag, ".win_line"},  int'(win_line),  e_line);
        check({tag, ".score_p0"},  int'(score_p0),  sc0);
        check({tag, ".score_p1"},  int'(score_p1),  sc1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   n, w, l, rvc, rv_at, seen_busy, seen_rv, player;
        logic [8:0] occ, col, cdrv;

        vecs[0] = '{9'h007, 9'h007, 2, 0};
        vecs[1] = '{9'h1FF, 9'h18D, 3, 0};
        vecs[2] = '{9'h155, 9'h000, 1, 6};
        vecs[3] = '{9'h124, 9'h124, 2, 5};
        vecs[4] = '{9'h092, 9'h16D, 1, 4};
        vecs[5] = '{9'h003, 9'h001, 0, 0};
        vecs[6] = '{9'h1FF, 9'h1D5, 2, 2};
        vecs[7] = '{9'h049, 9'h1B6, 1, 3};

        // reset state
        repeat (3) tick();
        check("rst.busy", int'(busy), 0);
        check("rst.result_valid", int'(result_valid), 0);
        check_all("rst");
        rst = 1'b0;
        tick();

        // vector table with cycle-exact latency
        foreach (vecs[i]) begin
            new_round();
            set_board(vecs[i].occ, vecs[i].col);
            for (int k = 1; k <= 11; k++) begin
                tick();
                check($sformatf("vec%0d.busy@%0d", i, k), int'(busy), (k >= 2 && k <= 10) ? 1 : 0);
                check($sformatf("vec%0d.rv@%0d", i, k), int'(result_valid), (k == 11) ? 1 : 0);
            end
            apply_result(vecs[i].win, vecs[i].line);
            check_all($sformatf("vec%0d", i));
        end

        // board change mid-scan restarts the scan
        new_round();
        set_board(9'h001, 9'h000);
        repeat (5) tick();
        check("abort.busy_first", int'(busy), 1);
        set_board(9'h007, 9'h000);
        rvc = 0; rv_at = 0; seen_busy = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (result_valid) begin rvc++; rv_at = k; end
            if (k <= 10 && !busy) seen_busy = 0;
        end
        check("abort.busy_held", seen_busy, 1);
        check("abort.rv_count", rvc, 1);
        check("abort.rv_at", rv_at, 11);
        apply_result(1, 0);
        check_all("abort");

        // board frozen while game over, then clr_game keeps scores
        set_board(9'h1FF, 9'h1FF);
        seen_busy = 0; seen_rv = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (busy) seen_busy = 1;
            if (result_valid) seen_rv = 1;
        end
        check("frozen.busy", seen_busy, 0);
        check("frozen.rv", seen_rv, 0);
        check_all("frozen");
        new_round();
        check_all("clr_game");

        // clr_game with a non-empty board rescans
        set_board(9'h124, 9'h124);
        wait_rv(n);
        check("rescan.first_lat", n, 11);
        apply_result(2, 5);
        check_all("rescan.first");
        clr_game = 1'b1;
        tick();
        clr_game = 1'b0;
        check("rescan.cleared", int'(game_over), 0);
        wait_rv(n);
        check("rescan.lat", n, 10);
        apply_result(2, 5);
        check_all("rescan");

        // clr_score in the EVAL cycle
        new_round();
        set_board(9'h007, 9'h007);
        repeat (10) tick();
        clr_score = 1'b1;
        tick();
        clr_score = 1'b0;
        check("clrscore.rv", int'(result_valid), 1);
        sc0 = 0; sc1 = 0;
        e_go = 1; e_win = 2; e_line = 0;
        check_all("clrscore");

        // clr_game in the EVAL cycle drops the increment
        new_round();
        set_board(9'h038, 9'h000);
        repeat (10) tick();
        clr_game = 1'b1;
        set_board(9'h000, 9'h000);
        tick();
        clr_game = 1'b0;
        check_all("clrgame_eval");
        repeat (3) tick();
        check("clrgame_eval.idle", int'(busy), 0);

        // saturation of player0 score
        for (int r = 0; r < 4; r++) begin
            new_round();
            set_board(9'h1C0, 9'h000);
            wait_rv(n);
            check($sformatf("sat%0d.lat", r), n, 11);
            apply_result(1, 2);
            check_all($sformatf("sat%0d", r));
        end

        // game_over hold time
        new_round();
        set_board(9'h054, 9'h054);
        wait_rv(n);
        apply_result(2, 7);
        check_all("hold.set");
        repeat (19) tick();
        check("hold.at19", int'(game_over), 1);
        tick();
`ifdef GAME_JUDGE_AUTOCLR_EN
        check("hold.at20", int'(game_over), 0);
        check("hold.winner20", int'(winner), 0);
        check("hold.score_kept", int'(score_p1), sc1);
`else
        check("hold.at20", int'(game_over), 1);
        check("hold.winner20", int'(winner), 2);
`endif

        // randomized games against the line model
        for (int g = 0; g < 30; g++) begin
            new_round();
            occ = '0; col = '0;
            player = int'($urandom_range(0, 1));
            for (int mv = 0; mv < 9; mv++) begin
                int idx;
                do idx = int'($urandom_range(0, 8)); while (occ[idx]);
                occ[idx] = 1'b1;
                col[idx] = player[0];
                cdrv = (col & occ) | (9'($urandom) & ~occ);
                set_board(occ, cdrv);
                wait_rv(n);
                check($sformatf("rnd%0d.%0d.lat", g, mv), n, 11);
                judge(occ, col, w, l);
                apply_result(w, l);
                check_all($sformatf("rnd%0d.%0d", g, mv));
                if (w != 0) break;
                if ($urandom_range(0, 3) != 0) player = 1 - player;
            end
        end

        // reset mid-scan
        new_round();
        set_board(9'h007, 9'h000);
        repeat (5) tick();
        rst = 1'b1;
        set_board(9'h000, 9'h000);
        tick();
        sc0 = 0; sc1 = 0; e_go = 0; e_win = 0; e_line = 0;
        check("midrst.busy", int'(busy), 0);
        check_all("midrst");
        rst = 1'b0;
        repeat (2) tick();
        check("midrst.idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
